// File: rtl/cla_seq_multiplier.sv
// cla_seq_multiplier: shift-and-add unsigned multiplier driving an external CLA adder each RUN cycle.
// Optional MULT_ZERO_BYPASS_EN: zero operands skip RUN and finish with product 0.
module cla_seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] m, q, acc;
  logic [CW-1:0]    count;
  always_comb begin
    busy    = state != IDLE;
    done    = state == DONE;
    add_a   = state == RUN ? acc : '0;
    add_b   = (state == RUN && q[0]) ? m : '0;
    add_cin = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      m       <= '0;
      q       <= '0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
`ifdef MULT_ZERO_BYPASS_EN
          if (a_in == '0 || b_in == '0) begin
            product <= '0;
            state   <= DONE;
          end else
`endif
          begin
            m     <= a_in;
            q     <= b_in;
            acc   <= '0;
            count <= CW'(WIDTH);
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= {add_cout, add_sum[WIDTH-1:1]};
          q     <= {add_sum[0], q[WIDTH-1:1]};
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            product <= {add_cout, add_sum, q[WIDTH-1:1]};
            state   <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_seq_multiplier.sv
// tb_cla_seq_multiplier: directed vectors, expected products queued and checked by a done monitor.
module tb_cla_seq_multiplier;
  logic        clk = 0, rst = 1, start = 0;
  logic [7:0]  a_in = 0, b_in = 0;
  logic        busy, done, add_cin, add_cout;
  logic [15:0] product;
  logic [7:0]  add_a, add_b, add_sum;
  logic [15:0] expq[$];
  logic [15:0] e;
  int          errors = 0, checks = 0;

  cla_seq_multiplier dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .product(product),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) if (!rst && done) begin
    if (expq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done: got product %h expected no done", product);
    end else begin
      e = expq.pop_front();
      chk("product", product, e);
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic wait_done(input string name, input int lat);
    int n = 0;
    while (!done && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    chk({name, "_latency"}, 16'(n), 16'(lat));
    @(posedge clk);
    #1 chk({name, "_idle"}, {15'b0, busy}, 16'h0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_product", product, 16'h0000);
    chk("rst_busy", {15'b0, busy}, 16'h0);
    chk("rst_done", {15'b0, done}, 16'h0);
    chk("rst_add_a", {8'b0, add_a}, 16'h0);
    chk("rst_add_b", {8'b0, add_b}, 16'h0);
    rst = 0;
    @(posedge clk);
    issue(8'd13, 8'd11);
    expq.push_back(16'h008F);
    chk("run_busy", {15'b0, busy}, 16'h1);
    chk("run_cin", {15'b0, add_cin}, 16'h0);
    wait_done("m13x11", 8);
    chk("hold_product", product, 16'h008F);
    chk("idle_add_a", {8'b0, add_a}, 16'h0);
    issue(8'd255, 8'd255);
    expq.push_back(16'hFE01);
    wait_done("m255x255", 8);
    issue(8'd5, 8'd6);
    expq.push_back(16'h001E);
    repeat (2) @(posedge clk);
    @(negedge clk);
    a_in  = 8'd9;
    b_in  = 8'd9;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    wait_done("m5x6_ignore", 5);
    repeat (3) @(posedge clk);
    chk("no_extra_done_q", 16'(expq.size()), 16'h0);
    issue(8'd200, 8'd3);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    chk("abort_busy", {15'b0, busy}, 16'h0);
    chk("abort_product", product, 16'h0000);
    chk("abort_done", {15'b0, done}, 16'h0);
    repeat (12) @(posedge clk);
    issue(8'd7, 8'd6);
    expq.push_back(16'h002A);
    wait_done("m7x6", 8);
    issue(8'd0, 8'd200);
    expq.push_back(16'h0000);
`ifdef MULT_ZERO_BYPASS_EN
    wait_done("m0x200", 0);
`else
    wait_done("m0x200", 8);
`endif
    repeat (3) @(posedge clk);
    chk("queue_empty", 16'(expq.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
